lane_sensor_tracker: RTL and testbench

//  Upstream feeder for Breadboard. Turns raw per-lane vehicle sensors into the per-lane

---
 rtl/lane_sensor_tracker.sv | 137 +++++++++++++
 tb/tb_lane_sensor_tracker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_sensor_tracker.sv
// Purpose: per-lane car counting from arrive/depart edges plus an arbitrated one-hot emergency request.
// Latency: counts and emergency outputs change on the edge that detects the event; a new request is served one edge after it is pending.
// Backpressure: none; the sink must accept every cycle, and requests that arrive while a lane is served wait in a pending vector.
module lane_sensor_tracker #(
    parameter int LANES       = 8,
    parameter int CNT_W       = 8,
    parameter int EMG_TIMEOUT = 64,
    parameter int HOLDOFF     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       arrive,
    input  logic [LANES-1:0]       depart,
    input  logic [LANES-1:0]       emgDetect,
    output logic [LANES*CNT_W-1:0] laneCounts,
    output logic                   emgSignal,
    output logic [LANES-1:0]       emgLane,
    output logic [LANES-1:0]       countErr
);

    localparam int TMR_W = $clog2(EMG_TIMEOUT + 1);
    localparam int HLD_W = $clog2(HOLDOFF + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(EMG_TIMEOUT - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [LANES-1:0] arrive_prev, depart_prev, emg_prev;
    logic [LANES-1:0] arrive_evt, depart_evt, emg_evt;
    logic [LANES-1:0] pending_q, pending_d;
    logic [LANES-1:0] pick;
    logic [LANES-1:0] emg_lane_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [HLD_W-1:0] hold_q, hold_d;
    logic             emg_signal_d;
    logic             serve;
    logic             served_depart;

    // A rising level is one event; a held level is not re-counted.
    assign arrive_evt = arrive & ~arrive_prev;
    assign depart_evt = depart & ~depart_prev;
    assign emg_evt    = emgDetect & ~emg_prev;

    assign served_depart = |(depart_evt & emgLane);

    // One-flop history of every sensor input for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arrive_prev <= '0;
            depart_prev <= '0;
            emg_prev    <= '0;
        end else begin
            arrive_prev <= arrive;
            depart_prev <= depart;
            emg_prev    <= emgDetect;
        end
    end

    // Saturating per-lane counts; a depart at zero latches a sticky underflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            laneCounts <= '0;
            countErr   <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (arrive_evt[i] && !depart_evt[i]) begin
                    if (laneCounts[i*CNT_W +: CNT_W] != CNT_MAX)
                        laneCounts[i*CNT_W +: CNT_W] <= laneCounts[i*CNT_W +: CNT_W] + CNT_W'(1);
                end else if (depart_evt[i] && !arrive_evt[i]) begin
                    if (laneCounts[i*CNT_W +: CNT_W] != '0)
                        laneCounts[i*CNT_W +: CNT_W] <= laneCounts[i*CNT_W +: CNT_W] - CNT_W'(1);
                    else
                        countErr[i] <= 1'b1;
                end
            end
        end
    end

    // Emergency FSM state, arbitration bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            timer_q   <= '0;
            hold_q    <= '0;
            emgSignal <= 1'b0;
            emgLane   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            hold_q    <= hold_d;
            emgSignal <= emg_signal_d;
            emgLane   <= emg_lane_d;
        end
    end

    // Next state; the edge that ends the holdoff also arbitrates, so the gap is exactly HOLDOFF cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pending_q) state_d = ACTIVE;
            ACTIVE:  if (served_depart || timer_q == TMR_LAST) state_d = HOLD;
            HOLD:    if (hold_q == HLD_LAST) state_d = (|pending_q) ? ACTIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Highest pending lane wins (w1 first); computes next pending, timers and outputs.
    always_comb begin
        pick = '0;
        for (int i = 0; i < LANES; i++) begin
            if (pending_q[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        serve        = (state_q != ACTIVE) && (state_d == ACTIVE);
        pending_d    = (pending_q & ~(serve ? pick : '0)) | emg_evt;
        timer_d      = timer_q;
        hold_d       = '0;
        emg_signal_d = (state_d == ACTIVE);
        emg_lane_d   = '0;
        if (serve) begin
            timer_d    = '0;
            emg_lane_d = pick;
        end else if (state_d == ACTIVE) begin
            timer_d    = timer_q + TMR_W'(1);
            emg_lane_d = emgLane;
        end
        if (state_d == HOLD && state_q == HOLD)
            hold_d = hold_q + HLD_W'(1);
    end

endmodule

// File: tb/tb_lane_sensor_tracker.sv
// Purpose: self-checking bench for lane_sensor_tracker (directed table, corner sequences, random vs. model).
// Latency: outputs are sampled 1 ns after each rising edge and compared with the model state for that edge.
// Backpressure: not applicable; inputs are driven every cycle.
module tb_lane_sensor_tracker;

    localparam int TO = 64;
    localparam int HO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  arrive, depart, emgDetect;
    logic [63:0] laneCounts;
    logic        emgSignal;
    logic [7:0]  emgLane, countErr;

    always #5 clk = ~clk;

    lane_sensor_tracker #(
        .LANES(8), .CNT_W(8), .EMG_TIMEOUT(TO), .HOLDOFF(HO)
    ) dut (
        .clk(clk), .rst(rst), .arrive(arrive), .depart(depart), .emgDetect(emgDetect),
        .laneCounts(laneCounts), .emgSignal(emgSignal), .emgLane(emgLane), .countErr(countErr)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: integer counts, pending flags, and the served lane with its elapsed/remaining time.
    int m_cnt [8];
    bit m_err [8];
    bit m_pend[8];
    bit pa[8], pd[8], pe[8];
    int serve_lane;
    int act_cycles;
    int gap;

    typedef struct {
        logic [7:0] a, d, e;
        logic [7:0] cw1, cn2, err;
        logic       sig;
        logic [7:0] lane;
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_cnt[i] = 0; m_err[i] = 0; m_pend[i] = 0;
            pa[i] = 0; pd[i] = 0; pe[i] = 0;
        end
        serve_lane = -1; act_cycles = 0; gap = 0;
    endtask

    function automatic int top_pending();
        for (int i = 7; i >= 0; i--) if (m_pend[i]) return i;
        return -1;
    endfunction

    task automatic model_step(input logic [7:0] a, input logic [7:0] d, input logic [7:0] e);
        bit ae[8], de[8], ee[8];
        int pick;
        for (int i = 0; i < 8; i++) begin
            ae[i] = a[i] && !pa[i]; pa[i] = a[i];
            de[i] = d[i] && !pd[i]; pd[i] = d[i];
            ee[i] = e[i] && !pe[i]; pe[i] = e[i];
            if (ae[i] && !de[i]) begin
                if (m_cnt[i] < 255) m_cnt[i]++;
            end else if (de[i] && !ae[i]) begin
                if (m_cnt[i] > 0) m_cnt[i]--; else m_err[i] = 1;
            end
        end
        pick = -1;
        if (serve_lane >= 0) begin
            if (de[serve_lane] || act_cycles == TO) begin
                serve_lane = -1;
                gap = HO;
            end else begin
                act_cycles++;
            end
        end else if (gap > 0) begin
            gap--;
            if (gap == 0) pick = top_pending();
        end else begin
            pick = top_pending();
        end
        if (pick >= 0) begin
            serve_lane = pick;
            act_cycles = 1;
            m_pend[pick] = 0;
        end
        for (int i = 0; i < 8; i++) if (ee[i]) m_pend[i] = 1;
    endtask

    task automatic check_model();
        logic [63:0] ec;
        logic [7:0]  ee, el;
        for (int i = 0; i < 8; i++) begin
            ec[i*8 +: 8] = 8'(m_cnt[i]);
            ee[i] = m_err[i];
        end
        el = (serve_lane >= 0) ? 8'(1 << serve_lane) : 8'h00;
        check("model_counts", laneCounts, ec);
        check("model_err", {56'd0, countErr}, {56'd0, ee});
        check("model_sig", {63'd0, emgSignal}, {63'd0, serve_lane >= 0});
        check("model_lane", {56'd0, emgLane}, {56'd0, el});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(arrive, depart, emgDetect);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        arrive = '0; depart = '0; emgDetect = '0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int hi;
        rst = 1'b0; arrive = '0; depart = '0; emgDetect = '0;
        model_reset();

        // Reset held while inputs toggle: everything stays cleared.
        for (int c = 0; c < 6; c++) begin
            arrive = 8'($urandom); depart = 8'($urandom); emgDetect = 8'($urandom);
            @(posedge clk); #1;
            check("rst_counts", laneCounts, 64'd0);
            check("rst_sig", {63'd0, emgSignal}, 64'd0);
            check("rst_lane", {56'd0, emgLane}, 64'd0);
            check("rst_err", {56'd0, countErr}, 64'd0);
        end
        do_reset();

        // Counting, underflow, then priority arbitration and holdoff.
        //            arrive depart emg    w1     n2     err    sig  lane
        tbl[0]  = '{8'h80, 8'h00, 8'h00, 8'd1, 8'd0, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{8'h00, 8'h00, 8'h00, 8'd1, 8'd0, 8'h00, 1'b0, 8'h00};
        tbl[2]  = '{8'h80, 8'h00, 8'h00, 8'd2, 8'd0, 8'h00, 1'b0, 8'h00};
        tbl[3]  = '{8'h00, 8'h00, 8'h00, 8'd2, 8'd0, 8'h00, 1'b0, 8'h00};
        tbl[4]  = '{8'h80, 8'h00, 8'h00, 8'd3, 8'd0, 8'h00, 1'b0, 8'h00};
        tbl[5]  = '{8'h00, 8'h00, 8'h00, 8'd3, 8'd0, 8'h00, 1'b0, 8'h00};
        tbl[6]  = '{8'h00, 8'h80, 8'h00, 8'd2, 8'd0, 8'h00, 1'b0, 8'h00};
        tbl[7]  = '{8'h00, 8'h01, 8'h00, 8'd2, 8'd0, 8'h01, 1'b0, 8'h00};
        tbl[8]  = '{8'h00, 8'h00, 8'h00, 8'd2, 8'd0, 8'h01, 1'b0, 8'h00};
        tbl[9]  = '{8'h00, 8'h00, 8'h0C, 8'd2, 8'd0, 8'h01, 1'b0, 8'h00};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 8'd2, 8'd0, 8'h01, 1'b1, 8'h08};
        tbl[11] = '{8'h00, 8'h00, 8'h00, 8'd2, 8'd0, 8'h01, 1'b1, 8'h08};
        tbl[12] = '{8'h00, 8'h08, 8'h00, 8'd2, 8'd0, 8'h09, 1'b0, 8'h00};
        tbl[13] = '{8'h00, 8'h00, 8'h00, 8'd2, 8'd0, 8'h09, 1'b0, 8'h00};
        tbl[14] = '{8'h00, 8'h00, 8'h00, 8'd2, 8'd0, 8'h09, 1'b0, 8'h00};
        tbl[15] = '{8'h00, 8'h00, 8'h00, 8'd2, 8'd0, 8'h09, 1'b0, 8'h00};
        tbl[16] = '{8'h00, 8'h00, 8'h00, 8'd2, 8'd0, 8'h09, 1'b1, 8'h04};
        tbl[17] = '{8'h00, 8'h00, 8'h00, 8'd2, 8'd0, 8'h09, 1'b1, 8'h04};
        for (int r = 0; r < 18; r++) begin
            arrive = tbl[r].a; depart = tbl[r].d; emgDetect = tbl[r].e;
            tick();
            check($sformatf("tbl%0d_w1", r), {56'd0, laneCounts[63:56]}, {56'd0, tbl[r].cw1});
            check($sformatf("tbl%0d_n2", r), {56'd0, laneCounts[7:0]}, {56'd0, tbl[r].cn2});
            check($sformatf("tbl%0d_err", r), {56'd0, countErr}, {56'd0, tbl[r].err});
            check($sformatf("tbl%0d_sig", r), {63'd0, emgSignal}, {63'd0, tbl[r].sig});
            check($sformatf("tbl%0d_lane", r), {56'd0, emgLane}, {56'd0, tbl[r].lane});
        end

        // Saturation, simultaneous arrive/depart, held level.
        do_reset();
        for (int k = 0; k < 260; k++) begin
            arrive = 8'h10; tick();
            arrive = 8'h00; tick();
        end
        check("sat_s2", {56'd0, laneCounts[39:32]}, 64'd255);
        arrive = 8'h10; depart = 8'h10; tick();
        arrive = 8'h00; depart = 8'h00; tick();
        check("simul_s2", {56'd0, laneCounts[39:32]}, 64'd255);
        check("simul_err", {56'd0, countErr}, 64'd0);
        arrive = 8'h04;
        repeat (10) tick();
        arrive = 8'h00; tick();
        check("held_e2", {56'd0, laneCounts[23:16]}, 64'd1);

        // Timeout: exactly TO cycles high, then low.
        do_reset();
        emgDetect = 8'h20; tick();
        emgDetect = 8'h00;
        hi = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (emgSignal) hi++;
        end
        check("timeout_high_cycles", 64'(hi), 64'(TO));
        check("timeout_final_sig", {63'd0, emgSignal}, 64'd0);

        // Reset while serving with other requests pending.
        do_reset();
        emgDetect = 8'h23; tick();
        emgDetect = 8'h00; tick(); tick();
        check("midrst_lane_before", {56'd0, emgLane}, 64'h20);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("midrst_counts", laneCounts, 64'd0);
        check("midrst_sig", {63'd0, emgSignal}, 64'd0);
        check("midrst_lane", {56'd0, emgLane}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (emgSignal) hi++;
        end
        check("midrst_no_reassert", 64'(hi), 64'd0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            arrive    = 8'($urandom);
            depart    = 8'($urandom & $urandom & $urandom);
            emgDetect = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
